// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions.
// Holds the per-stage payload widths and the bit positions of the control strobes
// that are packed into a pipe_stage_reg ctrl field at the instantiation site.
package cpu_pkg;

    // EX/MEM stage payload widths
    localparam int unsigned XM_DATA_W = 96;
    localparam int unsigned XM_CTRL_W = 8;

    // ID/EX stage payload widths
    localparam int unsigned DX_DATA_W = 128;
    localparam int unsigned DX_CTRL_W = 8;

    // Control-strobe bit positions within ctrl
    localparam int unsigned CTRL_REG_WRITE = 0;
    localparam int unsigned CTRL_MEM_READ  = 1;
    localparam int unsigned CTRL_MEM_WRITE = 2;
    localparam int unsigned CTRL_MEM_REG   = 3;
    localparam int unsigned CTRL_BRANCH    = 4;
    localparam int unsigned CTRL_JUMP      = 5;

endpackage

// File: rtl/pipe_slot.sv
// Single pipeline holding slot: valid flag, datapath payload and control payload.
// Ports:
//   clk, rst          clock, synchronous active-high reset (clears everything)
//   clear             turn the slot into a bubble (valid=0, ctrl=0); beats load
//   load              capture load_data/load_ctrl and mark valid
//   load_data/ctrl    payload to capture
//   valid/data/ctrl   held slot contents; ctrl is zero whenever valid is zero
module pipe_slot
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = XM_DATA_W,
    parameter int unsigned CTRL_W = XM_CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [CTRL_W-1:0] load_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [CTRL_W-1:0] ctrl_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else if (clear) begin
            // Data is left as-is on a bubble; only the strobes must die.
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= load_data;
            ctrl_q  <= load_ctrl;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign ctrl  = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready flow control, flush with
// bubble insertion and an optional skid slot.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      upstream handshake; in_data/in_ctrl the upstream payload
//   flush                  kill held and incoming entries
//   out_valid/out_ready    downstream handshake; out_data/out_ctrl presented payload
//   occupancy              number of held entries (0..2)
// SKID=1 keeps in_ready registered (a second slot absorbs the entry that arrives
// while downstream stalls); SKID=0 uses one slot and passes out_ready through.
module pipe_stage_reg
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = XM_DATA_W,
    parameter int unsigned CTRL_W = XM_CTRL_W,
    parameter bit          SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    logic              m_valid, s_valid;
    logic [DATA_W-1:0] m_data, s_data;
    logic [CTRL_W-1:0] m_ctrl, s_ctrl;

    logic              m_load, m_clear;
    logic [DATA_W-1:0] m_load_data;
    logic [CTRL_W-1:0] m_load_ctrl;

    logic accept, drain;

    assign accept = in_valid && in_ready;
    assign drain  = m_valid && out_ready;

    // With SKID=0 s_valid is constant zero and an accept into a full, non-draining
    // M cannot happen, so the same M update serves both builds.
    always_comb begin
        m_load  = 1'b0;
        m_clear = 1'b0;
        if (flush) begin
            m_clear = 1'b1;
        end else if (drain) begin
            if (s_valid || accept) m_load  = 1'b1;
            else                   m_clear = 1'b1;
        end else if (!m_valid && accept) begin
            m_load = 1'b1;
        end
    end

    // The skid entry is older than anything arriving, so it refills M first.
    assign m_load_data = s_valid ? s_data : in_data;
    assign m_load_ctrl = s_valid ? s_ctrl : in_ctrl;

    pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_slot_m (
        .clk       (clk),
        .rst       (rst),
        .clear     (m_clear),
        .load      (m_load),
        .load_data (m_load_data),
        .load_ctrl (m_load_ctrl),
        .valid     (m_valid),
        .data      (m_data),
        .ctrl      (m_ctrl)
    );

    if (SKID) begin : g_skid
        logic s_load, s_clear;

        assign s_load   = !flush && !drain && m_valid && accept;
        assign s_clear  = flush || (drain && s_valid);
        assign in_ready = !s_valid;

        pipe_slot #(
            .DATA_W (DATA_W),
            .CTRL_W (CTRL_W)
        ) u_slot_s (
            .clk       (clk),
            .rst       (rst),
            .clear     (s_clear),
            .load      (s_load),
            .load_data (in_data),
            .load_ctrl (in_ctrl),
            .valid     (s_valid),
            .data      (s_data),
            .ctrl      (s_ctrl)
        );
    end else begin : g_no_skid
        assign s_valid  = 1'b0;
        assign s_data   = '0;
        assign s_ctrl   = '0;
        assign in_ready = !m_valid || out_ready;
    end

    assign out_valid = m_valid;
    assign out_data  = m_data;
    assign out_ctrl  = m_ctrl & {CTRL_W{m_valid}};
    assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one SKID=1 instance and one SKID=0 instance.
module tb_pipe_stage_reg;

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    // SKID=1 instance signals
    logic          in_valid = 1'b0, in_ready, flush = 1'b0;
    logic [DW-1:0] in_data = '0, out_data;
    logic [CW-1:0] in_ctrl = '0, out_ctrl;
    logic          out_valid, out_ready = 1'b0;
    logic [1:0]    occupancy;

    // SKID=0 instance signals
    logic          in_valid0 = 1'b0, in_ready0, flush0 = 1'b0;
    logic [DW-1:0] in_data0 = '0, out_data0;
    logic [CW-1:0] in_ctrl0 = '0, out_ctrl0;
    logic          out_valid0, out_ready0 = 1'b0;
    logic [1:0]    occupancy0;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid0),
        .in_ready  (in_ready0),
        .in_data   (in_data0),
        .in_ctrl   (in_ctrl0),
        .flush     (flush0),
        .out_valid (out_valid0),
        .out_ready (out_ready0),
        .out_data  (out_data0),
        .out_ctrl  (out_ctrl0),
        .occupancy (occupancy0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; leaves time 1 unit past the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [CW-1:0] c);
        in_valid = 1'b1;
        in_data  = d;
        in_ctrl  = c;
    endtask

    initial begin
        // Reset with garbage presented upstream.
        in_valid = 1'b1;
        in_ctrl  = 8'hFF;
        in_data  = 16'h5555;
        in_valid0 = 1'b1;
        in_ctrl0  = 8'hFF;
        step();
        step();
        rst = 1'b0;
        in_valid  = 1'b0;
        in_valid0 = 1'b0;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_ctrl", {24'd0, out_ctrl}, 32'd0);
        check("rst_occupancy", {30'd0, occupancy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_skid0_in_ready", {31'd0, in_ready0}, 32'd1);

        // Streaming 1..4 with downstream always ready.
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            send(DW'(i), CW'(i));
            step();
            check($sformatf("stream_valid_%0d", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("stream_data_%0d", i), {16'd0, out_data}, i);
        end
        in_valid = 1'b0;
        step();
        check("stream_end_valid", {31'd0, out_valid}, 32'd0);
        check("stream_end_ctrl", {24'd0, out_ctrl}, 32'd0);

        // Backpressure: A,B fill M and S; C waits upstream.
        out_ready = 1'b0;
        send(16'h00A0, 8'h01);
        step();
        check("bp_occ_a", {30'd0, occupancy}, 32'd1);
        check("bp_ready_a", {31'd0, in_ready}, 32'd1);
        send(16'h00B0, 8'h02);
        step();
        check("bp_occ_b", {30'd0, occupancy}, 32'd2);
        check("bp_ready_b", {31'd0, in_ready}, 32'd0);
        send(16'h00C0, 8'h04);
        step();
        check("bp_hold_occ", {30'd0, occupancy}, 32'd2);
        check("bp_hold_data", {16'd0, out_data}, 32'h00A0);
        out_ready = 1'b1;
        step();
        check("bp_drain_b", {16'd0, out_data}, 32'h00B0);
        check("bp_drain_b_occ", {30'd0, occupancy}, 32'd1);
        check("bp_drain_b_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check("bp_drain_c", {16'd0, out_data}, 32'h00C0);
        check("bp_drain_c_ctrl", {24'd0, out_ctrl}, 32'h04);
        step();
        check("bp_empty", {31'd0, out_valid}, 32'd0);
        check("bp_empty_occ", {30'd0, occupancy}, 32'd0);

        // Flush while full, with an incoming entry in the flush cycle.
        out_ready = 1'b0;
        send(16'h00D0, 8'h11);
        step();
        send(16'h00E0, 8'h12);
        step();
        check("fl_full_occ", {30'd0, occupancy}, 32'd2);
        send(16'h00F0, 8'hAA);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", {31'd0, out_valid}, 32'd0);
        check("fl_out_ctrl", {24'd0, out_ctrl}, 32'd0);
        check("fl_occ", {30'd0, occupancy}, 32'd0);
        out_ready = 1'b1;
        step();
        check("fl_no_ghost", {31'd0, out_valid}, 32'd0);

        // Single entry drains into a bubble.
        send(16'h0077, 8'h15);
        step();
        in_valid = 1'b0;
        check("bub_valid", {31'd0, out_valid}, 32'd1);
        check("bub_ctrl_live", {24'd0, out_ctrl}, 32'h15);
        step();
        check("bub_valid_after", {31'd0, out_valid}, 32'd0);
        check("bub_ctrl_after", {24'd0, out_ctrl}, 32'h00);

        // Reset overrides a backpressured full state.
        out_ready = 1'b0;
        send(16'h0101, 8'h21);
        step();
        send(16'h0202, 8'h22);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        check("rst_bp_occ", {30'd0, occupancy}, 32'd0);
        check("rst_bp_valid", {31'd0, out_valid}, 32'd0);
        check("rst_bp_ready", {31'd0, in_ready}, 32'd1);

        // SKID=0: combinational in_ready from out_ready.
        out_ready0 = 1'b0;
        in_valid0  = 1'b1;
        in_data0   = 16'h0033;
        in_ctrl0   = 8'h08;
        step();
        in_data0 = 16'h0044;
        in_ctrl0 = 8'h10;
        #1;
        check("s0_full_ready", {31'd0, in_ready0}, 32'd0);
        check("s0_full_data", {16'd0, out_data0}, 32'h0033);
        out_ready0 = 1'b1;
        #1;
        check("s0_comb_ready", {31'd0, in_ready0}, 32'd1);
        step();
        check("s0_pass_data", {16'd0, out_data0}, 32'h0044);
        check("s0_pass_occ", {30'd0, occupancy0}, 32'd1);
        in_valid0 = 1'b0;
        step();
        check("s0_empty", {31'd0, out_valid0}, 32'd0);
        check("s0_empty_ctrl", {24'd0, out_ctrl0}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
